// File: rtl/reg_file_dump_ctrl.sv
// reg_file_dump_ctrl: walks the register file one index at a time and streams each value
// out over a valid/ready port while the core pipeline is held stalled.
module reg_file_dump_ctrl #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] core_rs_addr,
    output logic [DATA_W-1:0] core_rd_data,
    input  logic              core_wb_en,
    input  logic [ADDR_W-1:0] core_wb_addr,
    input  logic [DATA_W-1:0] core_wb_data,
    output logic              core_stall,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              dump_done,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        READ,
        SEND,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_dump_data;
    logic [ADDR_W-1:0] r_dump_addr;
    logic              r_dump_valid;
    logic              r_dump_done;
    logic              w_handshake;
    logic              w_at_last;

    assign w_handshake = r_dump_valid & dump_ready;
    assign w_at_last   = (r_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (dump_start) w_next_state = DRAIN;
            DRAIN:   w_next_state = READ;
            READ:    w_next_state = SEND;
            SEND:    if (w_handshake) w_next_state = w_at_last ? DONE : READ;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The beat is captured at the end of READ so dump_data stays frozen for all of SEND.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_idx        <= '0;
            r_dump_data  <= '0;
            r_dump_addr  <= '0;
            r_dump_valid <= 1'b0;
            r_dump_done  <= 1'b0;
        end else begin
            r_dump_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (dump_start) r_idx <= '0;
                end
                READ: begin
                    r_dump_data  <= rf_rd_data;
                    r_dump_addr  <= r_idx;
                    r_dump_valid <= 1'b1;
                end
                SEND: begin
                    if (w_handshake) begin
                        r_dump_valid <= 1'b0;
                        if (w_at_last) begin
                            r_dump_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // DRAIN still lets the in-flight writeback land; READ/SEND own the RF exclusively.
    always_comb begin
        core_stall = 1'b0;
        rf_rd_addr = core_rs_addr;
        rf_wr_en   = core_wb_en;
        case (r_state)
            DRAIN: core_stall = 1'b1;
            READ, SEND: begin
                core_stall = 1'b1;
                rf_rd_addr = r_idx;
                rf_wr_en   = 1'b0;
            end
            default: ;
        endcase
    end

    assign core_rd_data = rf_rd_data;
    assign rf_wr_addr   = core_wb_addr;
    assign rf_wr_data   = core_wb_data;
    assign dump_valid   = r_dump_valid;
    assign dump_addr    = r_dump_addr;
    assign dump_data    = r_dump_data;
    assign dump_done    = r_dump_done;
    assign dump_last    = r_dump_valid & (r_dump_addr == LAST_IDX);
    assign busy         = (r_state != IDLE);

endmodule
